// File: rtl/countdown_timer_if.sv
// countdown_timer_if: encoder-side inputs and display/control outputs of the cooking timer.
// Rev 1.0
`default_nettype none

interface countdown_timer_if;
  logic       clear;
  logic       enable;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       zero;
  logic       done;
  logic       running;

  modport master (
    output clear, enable, D, loadn, pgt_1Hz,
    input  sec_ones, sec_tens, min_ones, min_tens, zero, done, running
  );

  modport slave (
    input  clear, enable, D, loadn, pgt_1Hz,
    output sec_ones, sec_tens, min_ones, min_tens, zero, done, running
  );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS timer, digits shifted in from the keypad, counted down on 1 Hz ticks.
// Rev 1.0
`default_nettype none

module countdown_timer #(
  parameter int SEC_TENS_RELOAD = 5,
  parameter int DIGIT_MAX       = 9
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);

  localparam logic [3:0] c_RELOAD    = 4'(SEC_TENS_RELOAD);
  localparam logic [3:0] c_DIGIT_MAX = 4'(DIGIT_MAX);

  logic [3:0] r_so, r_st, r_mo, r_mt;
  logic       r_loadn_q, r_tick_q, r_done;
  logic [3:0] w_so, w_st, w_mo, w_mt;
  logic       w_zero, w_next_zero, w_load_evt, w_tick_evt;

  assign w_load_evt  = r_loadn_q & ~bus.loadn;
  assign w_tick_evt  = ~r_tick_q & bus.pgt_1Hz;
  assign w_zero      = (r_so == 4'd0) && (r_st == 4'd0) && (r_mo == 4'd0) && (r_mt == 4'd0);
  assign w_next_zero = (w_so == 4'd0) && (w_st == 4'd0) && (w_mo == 4'd0) && (w_mt == 4'd0);

  // Chained BCD borrow; min_tens never underflows because ticks are blocked at zero.
  always_comb begin
    w_so = r_so;
    w_st = r_st;
    w_mo = r_mo;
    w_mt = r_mt;
    if (r_so != 4'd0) begin
      w_so = r_so - 4'd1;
    end else begin
      w_so = 4'd9;
      if (r_st != 4'd0) begin
        w_st = r_st - 4'd1;
      end else begin
        w_st = c_RELOAD;
        if (r_mo != 4'd0) begin
          w_mo = r_mo - 4'd1;
        end else begin
          w_mo = 4'd9;
          w_mt = r_mt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_so      <= 4'd0;
      r_st      <= 4'd0;
      r_mo      <= 4'd0;
      r_mt      <= 4'd0;
      r_done    <= 1'b0;
      r_loadn_q <= 1'b1;
      r_tick_q  <= 1'b1;
    end else begin
      r_loadn_q <= bus.loadn;
      r_tick_q  <= bus.pgt_1Hz;
      r_done    <= 1'b0;
      if (bus.clear) begin
        r_so <= 4'd0;
        r_st <= 4'd0;
        r_mo <= 4'd0;
        r_mt <= 4'd0;
      end else if (bus.enable && w_tick_evt && !w_zero) begin
        r_so   <= w_so;
        r_st   <= w_st;
        r_mo   <= w_mo;
        r_mt   <= w_mt;
        r_done <= w_next_zero;
      end else if (!bus.enable && w_load_evt && (bus.D <= c_DIGIT_MAX)) begin
        r_mt <= r_mo;
        r_mo <= r_st;
        r_st <= r_so;
        r_so <= bus.D;
      end
    end
  end

  assign bus.sec_ones = r_so;
  assign bus.sec_tens = r_st;
  assign bus.min_ones = r_mo;
  assign bus.min_tens = r_mt;
  assign bus.zero     = w_zero;
  assign bus.done     = r_done;
  assign bus.running  = bus.enable & ~w_zero;

endmodule

`default_nettype wire
